// File: rtl/scroll_controller.sv
// Horizontal scroll sequencer for the background tile renderer: latches scroll and
// redraw requests, clamps the tile offset and launches one redraw per accepted request.
module scroll_controller #(
  parameter int TILEMAP_LENGTH = 100,
  parameter int SCREEN_TILES   = 20,
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          frame_tick,
  input  logic                          scroll_left,
  input  logic                          scroll_right,
  input  logic                          redraw_req,
  input  logic                          bg_done,
  output logic [(TILEMAP_LENGTH/15):0]  x_offset,
  output logic                          bg_enable,
  output logic                          busy,
  output logic                          at_left_edge,
  output logic                          at_right_edge
);

  localparam int OFF_W = (TILEMAP_LENGTH / 15) + 1;
  localparam logic [OFF_W-1:0] MAX_OFF      = OFF_W'(TILEMAP_LENGTH - SCREEN_TILES);
  localparam logic [OFF_W-1:0] ONE_OFF      = OFF_W'(1);
  localparam logic [OFF_W-1:0] ZERO_OFF     = OFF_W'(0);
  localparam logic [3:0]       HOLDOFF_LOAD = 4'(HOLDOFF_FRAMES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             req_l_r, req_r_r, pend_redraw_r;
  logic             req_l_s, req_r_s, pend_redraw_s;
  logic             req_l_raw_s, req_r_raw_s, cancel_s;
  logic [3:0]       hold_cnt_r, hold_cnt_s;
  logic [OFF_W-1:0] off_s;
  logic             consume_s;

  // Next-state, next-offset and holdoff counter decode
  always_comb begin
    state_s    = state_r;
    off_s      = x_offset;
    hold_cnt_s = hold_cnt_r;
    consume_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_tick) begin
          // Every latch is consumed here; an edge-blocked request is simply dropped.
          consume_s = 1'b1;
          if (req_r_r && (x_offset < MAX_OFF)) begin
            off_s   = x_offset + ONE_OFF;
            state_s = LAUNCH;
          end else if (req_l_r && (x_offset != ZERO_OFF)) begin
            off_s   = x_offset - ONE_OFF;
            state_s = LAUNCH;
          end else if (pend_redraw_r) begin
            state_s = LAUNCH;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        if (!bg_done) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = LAUNCH;
        end
      end
      WAIT_DONE: begin
        if (bg_done) begin
          hold_cnt_s = HOLDOFF_LOAD;
          state_s    = HOLDOFF;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_r == 4'd0) begin
          state_s = IDLE;
        end else if (frame_tick) begin
          hold_cnt_s = hold_cnt_r - 4'd1;
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sticky request capture; new pulses survive a same-cycle consume, opposing scrolls cancel
  always_comb begin
    req_l_raw_s   = (consume_s ? 1'b0 : req_l_r) | scroll_left;
    req_r_raw_s   = (consume_s ? 1'b0 : req_r_r) | scroll_right;
    cancel_s      = req_l_raw_s & req_r_raw_s;
    req_l_s       = req_l_raw_s & ~cancel_s;
    req_r_s       = req_r_raw_s & ~cancel_s;
    pend_redraw_s = (consume_s ? 1'b0 : pend_redraw_r) | redraw_req;
  end

  // State, latches and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r       <= IDLE;
      x_offset      <= ZERO_OFF;
      bg_enable     <= 1'b0;
      busy          <= 1'b0;
      at_left_edge  <= 1'b1;
      at_right_edge <= 1'b0;
      req_l_r       <= 1'b0;
      req_r_r       <= 1'b0;
      pend_redraw_r <= 1'b1;
      hold_cnt_r    <= 4'd0;
    end else begin
      state_r       <= state_s;
      x_offset      <= off_s;
      bg_enable     <= (state_s == LAUNCH);
      busy          <= (state_s != IDLE);
      at_left_edge  <= (off_s == ZERO_OFF);
      at_right_edge <= (off_s == MAX_OFF);
      req_l_r       <= req_l_s;
      req_r_r       <= req_r_s;
      pend_redraw_r <= pend_redraw_s;
      hold_cnt_r    <= hold_cnt_s;
    end
  end

endmodule

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
- Upstream sequencer for the background tile renderer. Owns the horizontal tile scroll offset.
- Accepts left/right scroll requests and forced-redraw requests, and clamps the offset to the tilemap bounds.
- Launches one full-screen background redraw per accepted request, using an enable/done handshake with the renderer.
- Keeps the offset stable for the whole redraw and rate-limits scrolling to a programmable number of frames.

Parameters:
- TILEMAP_LENGTH, 100, tilemap width in tiles.
- SCREEN_TILES, 20, tiles visible per row; max offset = TILEMAP_LENGTH - SCREEN_TILES (80 at defaults).
- HOLDOFF_FRAMES, 4, frame_tick pulses to wait after a redraw completes before the next launch; 4-bit range, 0 means no holdoff.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame; every launch is gated by it.
- scroll_left  in  1  one-cycle request: offset -1.
- scroll_right  in  1  one-cycle request: offset +1.
- redraw_req  in  1  one-cycle request: redraw with no offset change.
- bg_done  in  1  renderer done; high while the renderer is idle.
- x_offset  out  (TILEMAP_LENGTH/15)+1  current offset in tiles (7 bits at default), registered.
- bg_enable  out  1  renderer start, registered.
- busy  out  1  high in any state other than IDLE, registered.
- at_left_edge  out  1  x_offset == 0, registered.
- at_right_edge  out  1  x_offset == TILEMAP_LENGTH - SCREEN_TILES, registered.

Behaviour:
- Reset (async, resetn=0) sets:
  - state=IDLE, x_offset=0, bg_enable=0, busy=0, at_left_edge=1, at_right_edge=0.
  - req_l=0, req_r=0, holdoff count=0.
  - pend_redraw=1, so the first frame_tick after reset triggers the initial screen draw.
- Request latches (sticky, captured in every state):
  - scroll_left sets req_l; scroll_right sets req_r; redraw_req sets pend_redraw.
  - If req_l and req_r are both set after a capture, both clear (the requests cancel).
  - Latches clear only when consumed in IDLE.
- IDLE: evaluated only on a cycle with frame_tick=1.
  - req_r and x_offset < max: x_offset+1 next cycle, go to LAUNCH.
  - else req_l and x_offset > 0: x_offset-1 next cycle, go to LAUNCH.
  - else pend_redraw: offset unchanged, go to LAUNCH.
  - A request blocked by an edge is discarded silently: latch cleared, no launch.
  - All latches (req_l, req_r, pend_redraw) clear on any launch; one redraw serves all of them.
  - Requests arriving in the same cycle as the IDLE evaluation are captured for the next frame, not this one.
- LAUNCH:
  - bg_enable=1, held until bg_done is sampled 0, then go to WAIT_DONE with bg_enable=0 the following cycle.
  - Latency: frame_tick at cycle N gives bg_enable=1 and the new x_offset at N+1.
- WAIT_DONE: remain until bg_done=1, then load the holdoff count with HOLDOFF_FRAMES and go to HOLDOFF.
- HOLDOFF:
  - If the count is 0, go to IDLE next cycle.
  - Otherwise decrement on each frame_tick; go to IDLE the cycle after the count reaches 0.
- x_offset changes only on the IDLE->LAUNCH transition. It never changes in LAUNCH, WAIT_DONE or HOLDOFF.
- Edge flags update in the same cycle as x_offset.
- Arithmetic: unsigned. Compare against the constant TILEMAP_LENGTH - SCREEN_TILES; no wrap at either end.
- Reset mid-redraw: all outputs return to their reset values immediately, including bg_enable=0.

Test Plan:
- Release reset, bg_done=1, frame_tick at cycle 10 -> bg_enable=1 at cycle 11 with x_offset=0. Drive bg_done=0 at 13 -> bg_enable=0 at 14. Drive bg_done=1 at 40 -> HOLDOFF; busy stays 1 until 4 frame_ticks have passed.
- Idle at offset 5, pulse scroll_right, then frame_tick -> x_offset=6 one cycle after the tick, one launch. Repeat with scroll_left -> x_offset=5.
- Offset 80: scroll_right then frame_tick -> no bg_enable, x_offset stays 80, at_right_edge=1. Offset 0: scroll_left then frame_tick -> no launch.
- During WAIT_DONE, pulse scroll_right and scroll_left on separate cycles -> latches cancel; after holdoff, frame_tick gives no launch. Repeat with scroll_right twice -> exactly one +1 launch.
- Pulse redraw_req while idle at offset 30, then frame_tick -> launch with x_offset=30 unchanged.
- Assert resetn=0 during WAIT_DONE at offset 42 -> x_offset=0 and bg_enable=0 asynchronously; after release, initial redraw occurs on the first frame_tick.
